// File: rtl/mem_stage_mc.sv
// mem_stage_mc: multi-cycle MEM stage with req/ack memory bus, stall and byte-lane immediate merge; optional MEM_TIMEOUT_EN adds a wait-cycle abort.
module mem_stage_mc #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int LANE_W  = 1,
    parameter int TMO_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_op,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] reg_data2,
    input  logic [DATA_W-1:0] imm_mem,
    input  logic [DATA_W-1:0] imm_wb,
    input  logic              fwd_imm,
    input  logic [LANE_W-1:0] lane,
    output logic              stall,
    output logic              valid_out,
    output logic [DATA_W-1:0] mem_out,
    output logic [DATA_W-1:0] imm_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   merged;
    logic                accept;
    logic                done;
    logic                timeout;
    logic                unused_imm;

    assign unused_imm = ^imm_mem[DATA_W-1:8];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    assign timeout = (state_q == S_WAIT) && !mem_ack && (cnt_q == CNT_W'(TMO_CYC - 1));
    assign mem_err = err_q;
`else
    // The limit is irrelevant without the timeout build; folding it in keeps the parameter referenced.
    assign timeout = 1'b0 & (TMO_CYC > 0);
    assign mem_err = 1'b0;
`endif

    assign accept = (state_q == S_IDLE) && valid_in;
    assign done   = (state_q == S_WAIT) && (mem_ack || timeout);

    // Byte-lane merge: selected lane of the base is replaced by the low immediate byte.
    always_comb begin
        merged = fwd_imm ? imm_wb : reg_data2;
        merged[{lane, 3'b000} +: 8] = imm_mem[7:0];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: a memory op parks the stage in WAIT until ack (or timeout).
    always_comb begin
        state_d = (state_q == S_IDLE) ? ((valid_in && mem_op) ? S_WAIT : S_IDLE)
                                      : (done ? S_IDLE : S_WAIT);
    end

    // FSM outputs: stall is released combinationally in the cycle the access finishes; reset masks it.
    always_comb begin
        stall = rst && (((state_q == S_IDLE) && valid_in && mem_op) ||
                        ((state_q == S_WAIT) && !mem_ack && !timeout));
    end

    // Datapath next values: bus request captured at acceptance, results captured at completion.
    always_comb begin
        req_d   = (accept && mem_op) ? 1'b1 : (done ? 1'b0 : req_q);
        we_d    = (accept && mem_op) ? mem_write : we_q;
        addr_d  = (accept && mem_op) ? alu_out : addr_q;
        wdata_d = (accept && mem_op) ? reg_data2 : wdata_q;
        imm_d   = accept ? merged : imm_q;
        valid_d = (accept && !mem_op) || done;
        out_d   = (done && timeout) ? '0 : ((done && !we_q) ? mem_rdata : out_q);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            out_q   <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            out_q   <= out_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait counter and sticky error: count restarts on every entry to WAIT.
    always_comb begin
        cnt_d = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
        err_d = err_q || timeout;
    end

    // Timeout registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_out   = out_q;
    assign imm_out   = imm_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc: directed bench for mem_stage_mc (timeout scenario only when MEM_TIMEOUT_EN is defined).
module tb_mem_stage_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0, mem_op = 1'b0, mem_write = 1'b0, fwd_imm = 1'b0;
    logic [15:0] alu_out = '0, reg_data2 = '0, imm_mem = '0, imm_wb = '0, mem_rdata = '0;
    logic [0:0]  lane = '0;
    logic        mem_ack = 1'b0;
    logic        stall, valid_out, mem_req, mem_we, mem_err;
    logic [15:0] mem_out, imm_out, mem_addr, mem_wdata;
    int          errors = 0;
    int          checks = 0;

    mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .LANE_W(1), .TMO_CYC(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_op(mem_op), .mem_write(mem_write),
        .alu_out(alu_out), .reg_data2(reg_data2), .imm_mem(imm_mem), .imm_wb(imm_wb),
        .fwd_imm(fwd_imm), .lane(lane), .stall(stall), .valid_out(valid_out),
        .mem_out(mem_out), .imm_out(imm_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state, with a memory op already presented upstream
        valid_in = 1'b1; mem_op = 1'b1;
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_mem_out", mem_out, 0);
        chk("rst_imm_out", imm_out, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_err", mem_err, 0);
        valid_in = 1'b0; mem_op = 1'b0;
        @(negedge clk); rst = 1'b1;
        cyc();

        // merge on non-memory instructions
        valid_in = 1'b1; reg_data2 = 16'hAB00; imm_mem = 16'h00CD; lane = 1'b0;
        #1 chk("llb_stall", stall, 0);
        cyc();
        chk("llb_valid", valid_out, 1);
        chk("llb_imm", imm_out, 16'hABCD);
        chk("llb_mem_out", mem_out, 0);
        fwd_imm = 1'b1; imm_wb = 16'h12EF; lane = 1'b1;
        #1 chk("lhb_stall", stall, 0);
        cyc();
        chk("lhb_valid", valid_out, 1);
        chk("lhb_imm", imm_out, 16'hCDEF);
        valid_in = 1'b0;
        cyc();
        chk("nop_valid", valid_out, 0);

        // load acked in the third WAIT cycle
        valid_in = 1'b1; mem_op = 1'b1; mem_write = 1'b0; alu_out = 16'h0040;
        reg_data2 = 16'h5555; fwd_imm = 1'b0; lane = 1'b0; imm_mem = 16'h0077;
        #1 chk("ld_accept_stall", stall, 1);
        chk("ld_accept_req", mem_req, 0);
        cyc();
        chk("ld_w1_req", mem_req, 1);
        chk("ld_w1_addr", mem_addr, 16'h0040);
        chk("ld_w1_we", mem_we, 0);
        chk("ld_w1_stall", stall, 1);
        chk("ld_w1_valid", valid_out, 0);
        cyc();
        chk("ld_w2_req", mem_req, 1);
        chk("ld_w2_stall", stall, 1);
        chk("ld_w2_valid", valid_out, 0);
        cyc();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; valid_in = 1'b0; mem_op = 1'b0;
        #1 chk("ld_ack_stall", stall, 0);
        chk("ld_ack_req", mem_req, 1);
        cyc();
        mem_ack = 1'b0;
        chk("ld_done_req", mem_req, 0);
        chk("ld_done_valid", valid_out, 1);
        chk("ld_done_data", mem_out, 16'hBEEF);
        chk("ld_done_imm", imm_out, 16'h5577);
        cyc();
        chk("ld_after_valid", valid_out, 0);
        chk("ld_after_data", mem_out, 16'hBEEF);

        // store with immediate ack
        valid_in = 1'b1; mem_op = 1'b1; mem_write = 1'b1; alu_out = 16'h0010;
        reg_data2 = 16'h1234; imm_mem = 16'h0000;
        #1 chk("st_accept_stall", stall, 1);
        cyc();
        chk("st_req", mem_req, 1);
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 16'h1234);
        chk("st_addr", mem_addr, 16'h0010);
        mem_ack = 1'b1; mem_rdata = 16'hFFFF; valid_in = 1'b0; mem_op = 1'b0;
        #1 chk("st_ack_stall", stall, 0);
        cyc();
        mem_ack = 1'b0;
        chk("st_done_valid", valid_out, 1);
        chk("st_done_req", mem_req, 0);
        chk("st_mem_out_held", mem_out, 16'hBEEF);
        chk("st_imm", imm_out, 16'h1200);

        // back-to-back loads, each acked in the first WAIT cycle
        valid_in = 1'b1; mem_op = 1'b1; mem_write = 1'b0; alu_out = 16'h0100;
        cyc();
        chk("b2b1_addr", mem_addr, 16'h0100);
        mem_ack = 1'b1; mem_rdata = 16'h1111; alu_out = 16'h0102;
        #1 chk("b2b1_ack_stall", stall, 0);
        cyc();
        chk("b2b1_valid", valid_out, 1);
        chk("b2b1_data", mem_out, 16'h1111);
        #1 chk("b2b2_accept_stall", stall, 1);
        chk("b2b2_idle_req", mem_req, 0);
        cyc();
        chk("b2b2_req", mem_req, 1);
        chk("b2b2_addr", mem_addr, 16'h0102);
        chk("b2b2_valid_gap", valid_out, 0);
        mem_rdata = 16'h2222; valid_in = 1'b0; mem_op = 1'b0;
        cyc();
        mem_ack = 1'b0;
        chk("b2b2_valid", valid_out, 1);
        chk("b2b2_data", mem_out, 16'h2222);
        cyc();
        chk("b2b_after_valid", valid_out, 0);

`ifdef MEM_TIMEOUT_EN
        // no ack: abort after TMO_CYC wait cycles
        valid_in = 1'b1; mem_op = 1'b1; mem_write = 1'b0; alu_out = 16'h0300;
        cyc();
        valid_in = 1'b0; mem_op = 1'b0;
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            cyc();
        end
        chk("tmo_req_cycles", n, 8);
        chk("tmo_err", mem_err, 1);
        chk("tmo_mem_out", mem_out, 0);
        chk("tmo_valid", valid_out, 1);
        valid_in = 1'b1; mem_op = 1'b1; alu_out = 16'h0302;
        cyc();
        mem_ack = 1'b1; mem_rdata = 16'h3333; valid_in = 1'b0; mem_op = 1'b0;
        cyc();
        mem_ack = 1'b0;
        chk("tmo_good_data", mem_out, 16'h3333);
        chk("tmo_err_sticky", mem_err, 1);
`else
        chk("no_tmo_err", mem_err, 0);
`endif

        // asynchronous reset during WAIT
        valid_in = 1'b1; mem_op = 1'b1; mem_write = 1'b0; alu_out = 16'h0200;
        cyc();
        chk("ar_req_before", mem_req, 1);
        valid_in = 1'b0; mem_op = 1'b0;
        #1 rst = 1'b0;
        #1 chk("ar_req", mem_req, 0);
        chk("ar_stall", stall, 0);
        chk("ar_valid", valid_out, 0);
        chk("ar_err", mem_err, 0);
        @(negedge clk); rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'h4444;
        cyc();
        chk("ar_late_ack_valid", valid_out, 0);
        chk("ar_late_ack_req", mem_req, 0);
        chk("ar_late_ack_stall", stall, 0);
        cyc();
        chk("ar_late_ack_valid2", valid_out, 0);
        chk("ar_late_ack_data", mem_out, 0);
        mem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
